// File: rtl/sdram_pkg.sv
// sdram_pkg: shared FSM encoding, SDRAM address geometry and arbiter defaults.
package sdram_pkg;
    typedef enum logic [2:0] {IDLE = 3'b001, WAIT = 3'b010, DONE = 3'b100} state_t;
    localparam int BANK_W = 2;
    localparam int ROW_W = 13;
    localparam int COL_W = 10;
    localparam int DEF_ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_TIMEOUT = 1023;
    localparam int WDOG_W = 10;
endpackage

// File: rtl/sdram_rr_picker.sv
// sdram_rr_picker: first active request at or after rr_ptr, wrapping modulo NUM_CLIENTS.
module sdram_rr_picker #(
    parameter int NUM_CLIENTS = 2,
    parameter int IDX_W = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       grant,
    output logic                   valid
);
    logic [IDX_W:0] k;
    always_comb begin
        grant = '0;
        valid = 1'b0;
        k = '0;
        // Scan farthest offset first so the nearest requester is the last writer.
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            k = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            k = (k >= (IDX_W + 1)'(NUM_CLIENTS)) ? k - (IDX_W + 1)'(NUM_CLIENTS) : k;
            if (req[k[IDX_W-1:0]]) begin
                grant = k[IDX_W-1:0];
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of one SDRAM controller, one request per grant,
// with a watchdog that force-completes any transaction the controller never acks.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                          iclk,
    input  logic                          ireset_n,
    input  logic [NUM_CLIENTS-1:0]        ireq,
    input  logic [NUM_CLIENTS-1:0]        iwe,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] iaddr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] iwdata,
    output logic [NUM_CLIENTS-1:0]        oack,
    output logic [DATA_W-1:0]             ordata,
    output logic                          otimeout,
    output logic                          owrite_req,
    output logic [ADDR_W-1:0]             owrite_address,
    output logic [DATA_W-1:0]             owrite_data,
    input  logic                          iwrite_ack,
    output logic                          oread_req,
    output logic [ADDR_W-1:0]             oread_address,
    input  logic [DATA_W-1:0]             iread_data,
    input  logic                          iread_ack
);
    localparam int IDX_W = $clog2(NUM_CLIENTS);
    state_t state, state_n;
    logic [IDX_W-1:0] grant, grant_n, rr_ptr, rr_ptr_n, pick;
    logic pick_valid, we, we_n, wr_req_n, rd_req_n, timeout_n, hit, expire;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] wdata, wdata_n, rdata_n;
    logic [WDOG_W-1:0] wdog, wdog_n;
    logic [NUM_CLIENTS-1:0] ack_n;

    sdram_rr_picker #(.NUM_CLIENTS(NUM_CLIENTS), .IDX_W(IDX_W)) u_picker (
        .req(ireq), .rr_ptr(rr_ptr), .grant(pick), .valid(pick_valid)
    );

    assign owrite_address = addr;
    assign oread_address = addr;
    assign owrite_data = wdata;
    assign hit = we ? iwrite_ack : iread_ack;
    assign expire = (wdog + 1'b1) == WDOG_W'(TIMEOUT);

    always_comb begin
        state_n = state;
        grant_n = grant;
        rr_ptr_n = rr_ptr;
        we_n = we;
        addr_n = addr;
        wdata_n = wdata;
        wdog_n = wdog;
        wr_req_n = owrite_req;
        rd_req_n = oread_req;
        rdata_n = ordata;
        timeout_n = otimeout;
        ack_n = '0;
        case (state)
            IDLE: if (pick_valid) begin
                grant_n = pick;
                we_n = iwe[pick];
                addr_n = iaddr[pick*ADDR_W +: ADDR_W];
                wdata_n = iwdata[pick*DATA_W +: DATA_W];
                wr_req_n = iwe[pick];
                rd_req_n = ~iwe[pick];
                wdog_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                wdog_n = wdog + 1'b1;
                // A real ack wins over an expiry landing on the same cycle.
                if (hit || expire) begin
                    wr_req_n = 1'b0;
                    rd_req_n = 1'b0;
                    ack_n[grant] = 1'b1;
                    rdata_n = hit ? (we ? ordata : iread_data) : '0;
                    timeout_n = otimeout | ~hit;
                    state_n = DONE;
                end
            end
            DONE: begin
                rr_ptr_n = (grant == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= '0;
            we <= 1'b0;
            addr <= '0;
            wdata <= '0;
            wdog <= '0;
            owrite_req <= 1'b0;
            oread_req <= 1'b0;
            ordata <= '0;
            otimeout <= 1'b0;
            oack <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            rr_ptr <= rr_ptr_n;
            we <= we_n;
            addr <= addr_n;
            wdata <= wdata_n;
            wdog <= wdog_n;
            owrite_req <= wr_req_n;
            oread_req <= rd_req_n;
            ordata <= rdata_n;
            otimeout <= timeout_n;
            oack <= ack_n;
        end
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single-transaction SDRAM controller (25-bit word address, 16-bit data, separate write/read req/ack) between NUM_CLIENTS requesters.
- Uses round-robin arbitration and issues exactly one controller request per granted transaction.
- Returns the ack to the winning client, with read data for reads.
- A watchdog completes any transaction the controller fails to ack, so clients are never hung.

Parameters:
- NUM_CLIENTS, 2, number of requesters; legal range 2..4.
- ADDR_W, 25, word address width ({bank[1:0], row[12:0], col[9:0]}).
- DATA_W, 16, data width.
- TIMEOUT, 1023, maximum cycles spent in WAIT before forced completion; 10-bit counter.

Ports:
- iclk  in  1  system clock; same clock as the SDRAM controller.
- ireset_n  in  1  asynchronous active-low reset.
- ireq  in  NUM_CLIENTS  per-client request level; held until that client's oack.
- iwe  in  NUM_CLIENTS  per-client direction: 1 = write, 0 = read.
- iaddr  in  NUM_CLIENTS*ADDR_W  packed client addresses; client k occupies slice k.
- iwdata  in  NUM_CLIENTS*DATA_W  packed client write data.
- oack  out  NUM_CLIENTS  one-cycle completion pulse to the granted client.
- ordata  out  DATA_W  read data; valid only while oack is high and the transaction was a read.
- otimeout  out  1  sticky flag: a watchdog expiry has occurred.
- owrite_req, owrite_address[ADDR_W], owrite_data[DATA_W]  out  controller write request.
- iwrite_ack  in  1  controller write completion pulse.
- oread_req, oread_address[ADDR_W]  out  controller read request.
- iread_data[DATA_W], iread_ack  in  controller read data, and its completion pulse.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state): state=IDLE; all req, oack and otimeout = 0; ordata=0; addresses and data = 0; rr_ptr=0; watchdog=0.
  - Top level drives the controller's active-high synchronous reset from ~ireset_n.
  - A reset mid-transaction abandons it; no oack is issued.
- IDLE:
  - If any ireq is set, grant the first requester found scanning rr_ptr, rr_ptr+1, … modulo NUM_CLIENTS.
  - Latch the grant index, iwe, iaddr slice and iwdata slice.
  - Set owrite_req (write) or oread_req (read), never both; go to WAIT.
  - With no ireq set, remain in IDLE with all outputs quiet.
- WAIT:
  - req, address and data are held stable; watchdog increments each cycle.
  - On the matching ack (iwrite_ack for a write, iread_ack for a read):
    - clear req on that edge, so the controller sees req low when it returns to its idle state;
    - capture iread_data into ordata for a read;
    - go to DONE.
  - The non-matching ack is ignored.
  - Watchdog reaching TIMEOUT: clear req, set otimeout, set ordata=0, go to DONE.
- DONE (exactly 1 cycle):
  - oack[grant]=1.
  - rr_ptr = (grant+1) mod NUM_CLIENTS.
  - No arbitration and no ireq sampling this cycle; return to IDLE.
- Client rule:
  - Drop ireq by the edge that ends DONE.
  - Keeping ireq high with new iwe/iaddr/iwdata requests a further transaction, which competes in the next IDLE.
- Latency:
  - ireq sampled at edge E; controller req high from E+1.
  - Controller ack at edge A; oack high in the cycle after A.
  - Minimum IDLE→IDLE gap between transactions: 1 cycle.
- Simultaneous requests: only one grant per IDLE. rr_ptr guarantees every persistently requesting client is served within NUM_CLIENTS transactions.
- otimeout clears only on reset.

Decomposition:
- Shared package sdram_pkg holds:
  - state encoding (IDLE, WAIT, DONE, one-hot 3 bits);
  - address field widths BANK_W=2, ROW_W=13, COL_W=10, and ADDR_W/DATA_W defaults;
  - TIMEOUT default.
- One natural sub-module: sdram_rr_picker, purely combinational. Inputs: request vector and rr_ptr. Outputs: grant index and a valid bit. Instantiated once.

Test Plan:
- Single write: client0 ireq=1, iwe=1, iaddr=0x0123456, iwdata=0xBEEF; controller model acks 4 cycles after req → owrite_req high 4 cycles with those values, oack=01 one cycle after the ack, oread_req never high.
- Single read: client1 reads 0x1FFFFFF; model returns iread_data=0xA5A5 with iread_ack → ordata=0xA5A5 while oack=10; owrite_req stays 0.
- Round-robin: both clients hold ireq continuously for 6 transactions from reset → grant order 0,1,0,1,0,1; req drops the edge after each ack and is low in the following cycle.
- Back-to-back same client: client0 keeps ireq high through DONE with a new address → second request issued after exactly one IDLE cycle; no duplicate controller request for the first address.
- Timeout: model never acks; TIMEOUT=8 → req drops after 8 WAIT cycles, otimeout=1, oack pulses with ordata=0; the next client is then served normally and otimeout stays 1.
- Reset mid-WAIT: assert ireset_n=0 asynchronously while oread_req=1 → oread_req, oack and otimeout all 0 immediately without a clock edge; after release, first grant goes to client 0.
